// File: rtl/revo_pattern_generator.sv
// Programmable revolution-marker word generator for serializer lanes (one word per clock per channel).
// Optional sync realignment is built only when REVO_SYNC_REALIGN_EN is defined.
module revo_pattern_generator #(
    parameter int unsigned WORD_WIDTH     = 8,
    parameter int unsigned COUNTER_WIDTH  = 11,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned DEFAULT_PERIOD = 1280,
    parameter int unsigned OFFSET_WIDTH   = COUNTER_WIDTH + $clog2(WORD_WIDTH)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             config_load,
    input  logic [COUNTER_WIDTH-1:0]         period_minus_one,
    input  logic [OFFSET_WIDTH:0]            marker_bits,
    input  logic [CHANNELS*OFFSET_WIDTH-1:0] channel_offset,
    input  logic                             sync_in,
    output logic [CHANNELS*WORD_WIDTH-1:0]   revo_word,
    output logic [CHANNELS-1:0]              revo_pulse,
    output logic [31:0]                      revolution_count,
    output logic                             config_pending,
    output logic                             config_error
);

    localparam int unsigned MW = OFFSET_WIDTH + 1;
    // Two spare bits so g + T - offset never overflows.
    localparam int unsigned AW = OFFSET_WIDTH + 2;

    logic [COUNTER_WIDTH-1:0]         counter_q, period_act_q, period_shd_q, period_nxt;
    logic [MW-1:0]                    mbits_act_q, mbits_shd_q, mbits_nxt;
    logic [CHANNELS*OFFSET_WIDTH-1:0] offset_act_q, offset_shd_q, offset_nxt;
    logic                             pending_q, enable_r_q;

    logic                             sync_acc, wrap, advance, apply_cfg;
    logic [COUNTER_WIDTH-1:0]         pat_period, pat_index;
    logic [MW-1:0]                    pat_mbits;
    logic [CHANNELS*OFFSET_WIDTH-1:0] pat_offset;
    logic [CHANNELS*WORD_WIDTH-1:0]   pat_word;
    logic [CHANNELS-1:0]              pat_pulse;
    logic [AW-1:0]                    total_bits, base_bit, bit_g, bit_off, bit_dist, act_total;

`ifdef REVO_SYNC_REALIGN_EN
    assign sync_acc = sync_in;
`else
    logic unused_sync;
    assign unused_sync = sync_in;
    assign sync_acc    = 1'b0;
`endif

    assign wrap      = (counter_q == period_act_q);
    assign advance   = wrap | sync_acc;
    assign apply_cfg = advance & pending_q;

    assign period_nxt = apply_cfg ? period_shd_q : period_act_q;
    assign mbits_nxt  = apply_cfg ? mbits_shd_q  : mbits_act_q;
    assign offset_nxt = apply_cfg ? offset_shd_q : offset_act_q;

    // A sync emits index 0 under the configuration that takes effect on this edge.
    assign pat_period = sync_acc ? period_nxt : period_act_q;
    assign pat_mbits  = sync_acc ? mbits_nxt  : mbits_act_q;
    assign pat_offset = sync_acc ? offset_nxt : offset_act_q;
    assign pat_index  = sync_acc ? '0 : counter_q;

    always_comb begin
        pat_word   = '0;
        pat_pulse  = '0;
        bit_g      = '0;
        bit_dist   = '0;
        bit_off    = '0;
        total_bits = (AW'(pat_period) + AW'(1)) * AW'(WORD_WIDTH);
        base_bit   = AW'(pat_index) * AW'(WORD_WIDTH);
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            bit_off = AW'(pat_offset[c*OFFSET_WIDTH +: OFFSET_WIDTH]);
            if (bit_off < total_bits) begin
                for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
                    bit_g    = base_bit + AW'(WORD_WIDTH - 1 - i);
                    bit_dist = (bit_g >= bit_off) ? (bit_g - bit_off)
                                                  : (bit_g + total_bits - bit_off);
                    pat_word[c*WORD_WIDTH + i] = (bit_dist < AW'(pat_mbits));
                    if (bit_dist == '0) begin
                        pat_pulse[c] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        act_total    = (AW'(period_act_q) + AW'(1)) * AW'(WORD_WIDTH);
        config_error = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (AW'(offset_act_q[c*OFFSET_WIDTH +: OFFSET_WIDTH]) >= act_total) begin
                config_error = 1'b1;
            end
        end
    end

    assign config_pending = pending_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter_q        <= '0;
            period_act_q     <= COUNTER_WIDTH'(DEFAULT_PERIOD - 1);
            period_shd_q     <= COUNTER_WIDTH'(DEFAULT_PERIOD - 1);
            mbits_act_q      <= MW'(WORD_WIDTH);
            mbits_shd_q      <= MW'(WORD_WIDTH);
            offset_act_q     <= '0;
            offset_shd_q     <= '0;
            pending_q        <= 1'b0;
            enable_r_q       <= 1'b0;
            revo_word        <= '0;
            revo_pulse       <= '0;
            revolution_count <= '0;
        end else begin
            enable_r_q   <= enable;
            revo_word    <= enable_r_q ? pat_word : '0;
            revo_pulse   <= pat_pulse;
            period_act_q <= period_nxt;
            mbits_act_q  <= mbits_nxt;
            offset_act_q <= offset_nxt;
            if (advance) begin
                revolution_count <= revolution_count + 32'd1;
            end
            // A load coinciding with an apply stays pending for the following wrap.
            if (config_load) begin
                period_shd_q <= period_minus_one;
                mbits_shd_q  <= marker_bits;
                offset_shd_q <= channel_offset;
                pending_q    <= 1'b1;
            end else if (apply_cfg) begin
                pending_q    <= 1'b0;
            end
            if (sync_acc) begin
                counter_q <= (period_nxt == '0) ? '0 : COUNTER_WIDTH'(1);
            end else if (wrap) begin
                counter_q <= '0;
            end else begin
                counter_q <= counter_q + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_revo_pattern_generator.sv
// Self-checking bench for revo_pattern_generator: cycle scoreboard fed by a behavioural model,
// plus hand-derived vector table and multi-cycle corner-case sequences.
module tb_revo_pattern_generator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        config_load;
    logic [10:0] period_minus_one;
    logic [14:0] marker_bits;
    logic [27:0] channel_offset;
    logic        sync_in;
    logic [15:0] revo_word;
    logic [1:0]  revo_pulse;
    logic [31:0] revolution_count;
    logic        config_pending;
    logic        config_error;

`ifdef REVO_SYNC_REALIGN_EN
    localparam logic [7:0]  SYNC_WORD = 8'hFF;
    localparam logic [31:0] SYNC_REV  = 32'd4;
`else
    localparam logic [7:0]  SYNC_WORD = 8'h00;
    localparam logic [31:0] SYNC_REV  = 32'd3;
`endif

    revo_pattern_generator dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .config_load      (config_load),
        .period_minus_one (period_minus_one),
        .marker_bits      (marker_bits),
        .channel_offset   (channel_offset),
        .sync_in          (sync_in),
        .revo_word        (revo_word),
        .revo_pulse       (revo_pulse),
        .revolution_count (revolution_count),
        .config_pending   (config_pending),
        .config_error     (config_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          k;
        logic [15:0] word;
        logic [1:0]  pulse;
        logic [31:0] rev;
        logic        pend;
        logic        err;
    } exp_t;

    typedef struct {
        int          k;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [1:0]  p;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[10];

    int n_err = 0;
    int n_checks = 0;
    int last_k = 0;

    // Behavioural model state.
    int          m_cnt, m_per, m_mb, m_o0, m_o1;
    int          s_per, s_mb, s_o0, s_o1;
    bit          m_pend, m_en;
    logic [31:0] m_rev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_word(int pm1, int mb, int off, int k, bit en);
        int t, g, d;
        logic [7:0] w;
        w = '0;
        t = (pm1 + 1) * 8;
        if (en && off < t) begin
            for (int i = 0; i < 8; i++) begin
                g = k * 8 + 7 - i;
                d = ((g - off) % t + t) % t;
                w[i] = (d < mb);
            end
        end
        return w;
    endfunction

    function automatic bit model_pulse(int pm1, int off, int k);
        return (off < (pm1 + 1) * 8) && (off / 8 == k);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_per = 1279; m_mb = 8; m_o0 = 0; m_o1 = 0;
        s_per = 1279; s_mb = 8; s_o0 = 0; s_o1 = 0;
        m_pend = 0; m_en = 0; m_rev = '0;
        sb_q.delete();
    endtask

    // One clock: predict from the inputs now applied, then compare after the edge.
    task automatic step();
        exp_t e;
        bit wrap, sacc;
        int ep, emb, eo0, eo1, k, t;
        wrap = (m_cnt == m_per);
`ifdef REVO_SYNC_REALIGN_EN
        sacc = sync_in;
`else
        sacc = 1'b0;
`endif
        if (sacc && m_pend) begin
            ep = s_per; emb = s_mb; eo0 = s_o0; eo1 = s_o1;
        end else begin
            ep = m_per; emb = m_mb; eo0 = m_o0; eo1 = m_o1;
        end
        k = sacc ? 0 : m_cnt;
        e.k     = k;
        e.word  = {model_word(ep, emb, eo1, k, m_en), model_word(ep, emb, eo0, k, m_en)};
        e.pulse = {model_pulse(ep, eo1, k), model_pulse(ep, eo0, k)};
        if (wrap || sacc) m_rev = m_rev + 32'd1;
        e.rev = m_rev;
        if ((wrap || sacc) && m_pend) begin
            m_per = s_per; m_mb = s_mb; m_o0 = s_o0; m_o1 = s_o1; m_pend = 0;
        end
        if (config_load) begin
            s_per = int'(period_minus_one); s_mb = int'(marker_bits);
            s_o0 = int'(channel_offset[13:0]); s_o1 = int'(channel_offset[27:14]);
            m_pend = 1;
        end
        if (sacc) m_cnt = (m_per == 0) ? 0 : 1;
        else if (wrap) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        m_en = enable;
        t = (m_per + 1) * 8;
        e.pend = m_pend;
        e.err  = (m_o0 >= t) || (m_o1 >= t);
        sb_q.push_back(e);

        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        last_k = e.k;
        chk($sformatf("word k=%0d", e.k), 64'(revo_word), 64'(e.word));
        chk($sformatf("pulse k=%0d", e.k), 64'(revo_pulse), 64'(e.pulse));
        chk("revolution_count", 64'(revolution_count), 64'(e.rev));
        chk("pending/error", 64'({config_pending, config_error}), 64'({e.pend, e.err}));
    endtask

    task automatic run_until_cnt(input int target, input int budget, input string name);
        for (int n = 0; n < budget && m_cnt != target; n++) step();
        n_checks++;
        if (m_cnt != target) begin
            n_err++;
            $display("FAIL %s: counter %0d, expected %0d within %0d cycles", name, m_cnt, target,
                     budget);
        end
    endtask

    task automatic load_cfg(input int pm1, input int mb, input int o0, input int o1);
        period_minus_one = 11'(pm1);
        marker_bits      = 15'(mb);
        channel_offset   = {14'(o1), 14'(o0)};
        config_load      = 1'b1;
        step();
        config_load      = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_ff;
        logic [7:0] ch1_or;

        // Hand-derived words for P=10, marker 12 bits, offsets ch0=4, ch1=78 (T=80).
        for (int j = 0; j < 10; j++) tbl[j] = '{k: j, w0: 8'h00, w1: 8'h00, p: 2'b00};
        tbl[0] = '{k: 0, w0: 8'h0F, w1: 8'hFF, p: 2'b01};
        tbl[1] = '{k: 1, w0: 8'hFF, w1: 8'hC0, p: 2'b00};
        tbl[9] = '{k: 9, w0: 8'h00, w1: 8'h03, p: 2'b10};

        reset_n = 1'b0; enable = 1'b1; config_load = 1'b0; sync_in = 1'b0;
        period_minus_one = '0; marker_bits = '0; channel_offset = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset word", 64'(revo_word), 64'h0);
        chk("reset pulse", 64'(revo_pulse), 64'h0);
        chk("reset revolution_count", 64'(revolution_count), 64'h0);
        chk("reset pending/error", 64'({config_pending, config_error}), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Legacy defaults: one all-ones word per 1280; first index 0 masked by enable_r.
        n_ff = 0;
        for (int j = 0; j < 3840; j++) begin
            step();
            if (revo_word[7:0] == 8'hFF) n_ff++;
        end
        chk("default FF count", 64'(n_ff), 64'd2);
        chk("default revolutions", 64'(revolution_count), 64'd3);

        // Sync strobe at counter 500.
        run_until_cnt(500, 1300, "reach counter 500");
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        chk("sync word ch0", 64'(revo_word[7:0]), 64'(SYNC_WORD));
        chk("sync revolution_count", 64'(revolution_count), 64'(SYNC_REV));
        step();

        // Short period with wrapping ch1 marker, applied at the wrap.
        load_cfg(9, 12, 4, 78);
        run_until_cnt(0, 1300, "apply short config");
        for (int j = 0; j < 10; j++) begin
            step();
            chk($sformatf("table word k=%0d", tbl[j].k), 64'(revo_word), 64'({tbl[j].w1, tbl[j].w0}));
            chk($sformatf("table pulse k=%0d", tbl[j].k), 64'(revo_pulse), 64'(tbl[j].p));
        end

        // Mid-revolution load of an out-of-range ch1 offset.
        repeat (4) step();
        load_cfg(9, 12, 4, 200);
        chk("pending after load", 64'(config_pending), 64'd1);
        chk("error before apply", 64'(config_error), 64'd0);
        run_until_cnt(0, 20, "apply bad offset");
        chk("pending after apply", 64'(config_pending), 64'd0);
        chk("error with offset 200", 64'(config_error), 64'd1);
        ch1_or = '0;
        for (int j = 0; j < 10; j++) begin
            step();
            ch1_or = ch1_or | revo_word[15:8];
            if (j == 0) chk("ch0 index 0 new config", 64'(revo_word[7:0]), 64'h0F);
        end
        chk("ch1 silent with bad offset", 64'(ch1_or), 64'h0);
        load_cfg(9, 12, 4, 78);
        chk("error held until wrap", 64'(config_error), 64'd1);
        run_until_cnt(0, 20, "apply valid reload");
        chk("error cleared at wrap", 64'(config_error), 64'd0);

        // Asynchronous reset in the middle of a marker word, with a config pending.
        load_cfg(5, 8, 0, 0);
        step();
        chk("pre-reset marker word", 64'(revo_word), 64'hC0FF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset word", 64'(revo_word), 64'h0);
        chk("async reset pending", 64'(config_pending), 64'd0);
        chk("async reset revolution_count", 64'(revolution_count), 64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();

        // Enable low for 3 cycles masks exactly the next marker; phase is kept.
        n_ff = 0;
        for (int j = 0; j < 1278; j++) begin
            step();
            if (revo_word[7:0] == 8'hFF) n_ff++;
        end
        enable = 1'b0;
        repeat (3) begin
            step();
            if (revo_word[7:0] == 8'hFF) n_ff++;
        end
        enable = 1'b1;
        for (int j = 0; j < 1290; j++) begin
            step();
            if (revo_word[7:0] == 8'hFF) n_ff++;
        end
        chk("FF count with enable gap", 64'(n_ff), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
